// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Round-robin arbiter that shares one SRAM port between up to four requesters
// (index 0 = control unit). On a grant the winner's address, direction and
// write data are latched and a fixed-length SRAM access is run: one address
// setup cycle plus WAIT_CYCLES further cycles, then a one-cycle DONE state
// that pulses done to the winner. Read data is captured on the last access
// edge and held on rdata_o until the next read completes.
//
// Optional feature: define MEM_ARBITER_LOCK_EN to add the lock_i port and a
// bus-lock owner register, used for stack read-modify-write sequences. With
// the macro undefined the arbiter is pure round-robin.
//
// Ports:
//   clk_i        system clock, all state changes on the rising edge
//   reset_i      synchronous active-high reset
//   req_i        request level per requester, held until done
//   we_i         1 = write, 0 = read, sampled at grant
//   addr_i       flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   wdata_i      flattened write data, same packing
//   lock_i       bus-lock request (MEM_ARBITER_LOCK_EN only)
//   gnt_o        one-hot grant, high for the whole transaction
//   done_o       one-cycle completion pulse to the granted requester
//   rdata_o      last read data
//   busy_o       high in any state other than IDLE
//   mem_addr_o   SRAM address
//   mem_wdata_o  SRAM write data
//   mem_oe_o     SRAM output enable (active high)
//   mem_we_o     SRAM write enable (active high)
//   mem_rdata_i  SRAM read data
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ-1:0]         we_i,
    input  logic [NUM_REQ*ADDR_W-1:0]  addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]  wdata_i,
`ifdef MEM_ARBITER_LOCK_EN
    input  logic [NUM_REQ-1:0]         lock_i,
`endif
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         done_o,
    output logic [DATA_W-1:0]          rdata_o,
    output logic                       busy_o,
    output logic [ADDR_W-1:0]          mem_addr_o,
    output logic [DATA_W-1:0]          mem_wdata_o,
    output logic                       mem_oe_o,
    output logic                       mem_we_o,
    input  logic [DATA_W-1:0]          mem_rdata_i
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Elaboration-time parameter checks.
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("mem_arbiter: WAIT_CYCLES must be in 1..15");
    end
    if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
        $error("mem_arbiter: NUM_REQ must be in 2..4");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Index increment that wraps at NUM_REQ-1 (NUM_REQ need not be a power of two).
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] cur);
        logic [IDX_W-1:0] nxt;
        if (cur >= IDX_W'(NUM_REQ - 1)) begin
            nxt = {IDX_W{1'b0}};
        end else begin
            nxt = cur + IDX_W'(1);
        end
        return nxt;
    endfunction

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]    last_win_q, last_win_d;
    logic                we_lat_q, we_lat_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                busy_q, busy_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_oe_q, mem_oe_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

`ifdef MEM_ARBITER_LOCK_EN
    logic                lock_vld_q, lock_vld_d;
    logic [IDX_W-1:0]    lock_own_q, lock_own_d;
    logic [IDX_W-1:0]    win_q, win_d;
`endif

    logic                rr_found_s;
    logic [IDX_W-1:0]    rr_idx_s;
    logic [IDX_W-1:0]    cand_s;
    logic                grant_s;
    logic [IDX_W-1:0]    win_sel_s;
    logic                adv_rr_s;

    // Round-robin search starting one past the last winner.
    always_comb begin
        rr_found_s = 1'b0;
        rr_idx_s   = last_win_q;
        cand_s     = next_idx(last_win_q);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!rr_found_s && req_i[cand_s]) begin
                rr_found_s = 1'b1;
                rr_idx_s   = cand_s;
            end else begin
                rr_found_s = rr_found_s;
            end
            cand_s = next_idx(cand_s);
        end
    end

    // Winner selection: a requesting lock owner bypasses round-robin and
    // does not advance the round-robin pointer.
    always_comb begin
        grant_s   = rr_found_s;
        win_sel_s = rr_idx_s;
        adv_rr_s  = rr_found_s;
`ifdef MEM_ARBITER_LOCK_EN
        if (lock_vld_q && req_i[lock_own_q]) begin
            grant_s   = 1'b1;
            win_sel_s = lock_own_q;
            adv_rr_s  = 1'b0;
        end else begin
            grant_s   = rr_found_s;
        end
`endif
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_win_d  = last_win_q;
        we_lat_d    = we_lat_q;
        gnt_d       = gnt_q;
        done_d      = {NUM_REQ{1'b0}};
        busy_d      = busy_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_oe_d    = 1'b0;
        mem_we_d    = 1'b0;
        rdata_d     = rdata_q;
`ifdef MEM_ARBITER_LOCK_EN
        lock_vld_d  = lock_vld_q;
        lock_own_d  = lock_own_q;
        win_d       = win_q;
`endif

        case (state_q)
            ST_IDLE: begin
`ifdef MEM_ARBITER_LOCK_EN
                // Owner that stopped requesting gives up the lock.
                if (lock_vld_q && !req_i[lock_own_q]) begin
                    lock_vld_d = 1'b0;
                end else begin
                    lock_vld_d = lock_vld_q;
                end
`endif
                if (grant_s) begin
                    state_d     = ST_ACCESS;
                    cnt_d       = 4'(WAIT_CYCLES);
                    gnt_d       = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_sel_s;
                    busy_d      = 1'b1;
                    we_lat_d    = we_i[win_sel_s];
                    mem_addr_d  = addr_i[int'(win_sel_s)*ADDR_W +: ADDR_W];
                    mem_wdata_d = wdata_i[int'(win_sel_s)*DATA_W +: DATA_W];
                    // First access cycle is address setup: OE for reads, no WE.
                    mem_oe_d    = ~we_i[win_sel_s];
                    mem_we_d    = 1'b0;
`ifdef MEM_ARBITER_LOCK_EN
                    win_d       = win_sel_s;
`endif
                    if (adv_rr_s) begin
                        last_win_d = win_sel_s;
                    end else begin
                        last_win_d = last_win_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end

            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // Last access edge: reads capture SRAM data.
                    state_d  = ST_DONE;
                    done_d   = gnt_q;
                    mem_oe_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (!we_lat_q) begin
                        rdata_d = mem_rdata_i;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d    = cnt_q - 4'd1;
                    mem_oe_d = ~we_lat_q;
                    mem_we_d = we_lat_q;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                gnt_d   = {NUM_REQ{1'b0}};
                busy_d  = 1'b0;
`ifdef MEM_ARBITER_LOCK_EN
                // Winner's lock level in DONE decides ownership.
                lock_vld_d = lock_i[win_q];
                lock_own_d = win_q;
`endif
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = {NUM_REQ{1'b0}};
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            last_win_q  <= IDX_W'(NUM_REQ - 1);
            we_lat_q    <= 1'b0;
            gnt_q       <= {NUM_REQ{1'b0}};
            done_q      <= {NUM_REQ{1'b0}};
            busy_q      <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            mem_oe_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            rdata_q     <= {DATA_W{1'b0}};
`ifdef MEM_ARBITER_LOCK_EN
            lock_vld_q  <= 1'b0;
            lock_own_q  <= {IDX_W{1'b0}};
            win_q       <= {IDX_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_win_q  <= last_win_d;
            we_lat_q    <= we_lat_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_oe_q    <= mem_oe_d;
            mem_we_q    <= mem_we_d;
            rdata_q     <= rdata_d;
`ifdef MEM_ARBITER_LOCK_EN
            lock_vld_q  <= lock_vld_d;
            lock_own_q  <= lock_own_d;
            win_q       <= win_d;
`endif
        end
    end

    assign gnt_o       = gnt_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_oe_o    = mem_oe_q;
    assign mem_we_o    = mem_we_q;
    assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with the
// default parameters (NUM_REQ=4, ADDR_W=16, DATA_W=8, WAIT_CYCLES=2).
// Inputs change and outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int NR = 4;
    localparam int AW = 16;
    localparam int DW = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req;
    logic [NR-1:0]     we;
    logic [NR*AW-1:0]  addr;
    logic [NR*DW-1:0]  wdata;
`ifdef MEM_ARBITER_LOCK_EN
    logic [NR-1:0]     lock;
`endif
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     done;
    logic [DW-1:0]     rdata;
    logic              busy;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic              mem_oe;
    logic              mem_we;
    logic [DW-1:0]     mem_rdata;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .req_i(req),
        .we_i(we),
        .addr_i(addr),
        .wdata_i(wdata),
`ifdef MEM_ARBITER_LOCK_EN
        .lock_i(lock),
`endif
        .gnt_o(gnt),
        .done_o(done),
        .rdata_o(rdata),
        .busy_o(busy),
        .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_oe_o(mem_oe),
        .mem_we_o(mem_we),
        .mem_rdata_i(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int order[5] = '{0, 1, 2, 3, 0};

    initial begin
        reset     = 1'b1;
        req       = 4'b0000;
        we        = 4'b0000;
        addr      = {(NR*AW){1'b0}};
        wdata     = {(NR*DW){1'b0}};
        mem_rdata = 8'h00;
`ifdef MEM_ARBITER_LOCK_EN
        lock      = 4'b0000;
`endif
        step();
        step();

        // ---------------- reset state ----------------
        chk("rst_gnt",   32'(gnt),       32'h0);
        chk("rst_done",  32'(done),      32'h0);
        chk("rst_busy",  32'(busy),      32'h0);
        chk("rst_oe",    32'(mem_oe),    32'h0);
        chk("rst_we",    32'(mem_we),    32'h0);
        chk("rst_addr",  32'(mem_addr),  32'h0);
        chk("rst_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_rdata", 32'(rdata),     32'h0);

        // ---------------- single read from requester 0 ----------------
        reset            = 1'b0;
        req              = 4'b0001;
        we               = 4'b0000;
        addr[0*AW +: AW] = 16'h1234;
        mem_rdata        = 8'hA5;
        step();                                   // grant, ACCESS 1 (setup)
        chk("rd_gnt1",  32'(gnt),      32'h1);
        chk("rd_busy1", 32'(busy),     32'h1);
        chk("rd_oe1",   32'(mem_oe),   32'h1);
        chk("rd_we1",   32'(mem_we),   32'h0);
        chk("rd_addr1", 32'(mem_addr), 32'h1234);
        chk("rd_done1", 32'(done),     32'h0);
        step();                                   // ACCESS 2
        chk("rd_oe2",   32'(mem_oe),   32'h1);
        chk("rd_gnt2",  32'(gnt),      32'h1);
        step();                                   // ACCESS 3
        chk("rd_oe3",   32'(mem_oe),   32'h1);
        chk("rd_done3", 32'(done),     32'h0);
        step();                                   // DONE
        chk("rd_done4", 32'(done),     32'h1);
        chk("rd_gnt4",  32'(gnt),      32'h1);
        chk("rd_oe4",   32'(mem_oe),   32'h0);
        chk("rd_rdata", 32'(rdata),    32'hA5);
        chk("rd_addr4", 32'(mem_addr), 32'h1234);
        req       = 4'b0000;
        mem_rdata = 8'h11;
        step();                                   // IDLE
        chk("rd_gnt5",  32'(gnt),   32'h0);
        chk("rd_busy5", 32'(busy),  32'h0);
        chk("rd_done5", 32'(done),  32'h0);
        chk("rd_hold",  32'(rdata), 32'hA5);

        // ---------------- single write from requester 1 ----------------
        req               = 4'b0010;
        we                = 4'b0010;
        addr[1*AW +: AW]  = 16'h00FF;
        wdata[1*DW +: DW] = 8'h3C;
        step();                                   // setup cycle
        chk("wr_gnt1",   32'(gnt),       32'h2);
        chk("wr_we1",    32'(mem_we),    32'h0);
        chk("wr_oe1",    32'(mem_oe),    32'h0);
        chk("wr_addr1",  32'(mem_addr),  32'h00FF);
        chk("wr_wdata1", 32'(mem_wdata), 32'h3C);
        step();
        chk("wr_we2",    32'(mem_we),    32'h1);
        chk("wr_oe2",    32'(mem_oe),    32'h0);
        step();
        chk("wr_we3",    32'(mem_we),    32'h1);
        chk("wr_addr3",  32'(mem_addr),  32'h00FF);
        step();                                   // DONE
        chk("wr_done",   32'(done),      32'h2);
        chk("wr_we4",    32'(mem_we),    32'h0);
        chk("wr_rdata",  32'(rdata),     32'hA5);
        req = 4'b0000;
        we  = 4'b0000;
        step();
        chk("wr_idle",   32'(busy),      32'h0);

        // ---------------- input change mid-transaction ----------------
        req              = 4'b0001;
        addr[0*AW +: AW] = 16'h1000;
        mem_rdata        = 8'h5A;
        step();
        chk("chg_gnt",   32'(gnt),      32'h1);
        chk("chg_addr1", 32'(mem_addr), 32'h1000);
        addr[0*AW +: AW] = 16'h2000;
        we               = 4'b0001;
        step();
        chk("chg_addr2", 32'(mem_addr), 32'h1000);
        chk("chg_oe2",   32'(mem_oe),   32'h1);
        chk("chg_we2",   32'(mem_we),   32'h0);
        req = 4'b0000;                            // dropping req does not abort
        step();
        chk("chg_addr3", 32'(mem_addr), 32'h1000);
        step();
        chk("chg_done",  32'(done),     32'h1);
        chk("chg_rdata", 32'(rdata),    32'h5A);
        we = 4'b0000;
        step();

        // ---------------- fairness from reset ----------------
        reset = 1'b1;
        step();
        reset = 1'b0;
        req   = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            step();
            chk("fair_gnt",  32'(gnt),  32'd1 << order[t]);
            step();
            step();
            step();
            chk("fair_done", 32'(done), 32'd1 << order[t]);
            step();
            chk("fair_idle", 32'(busy), 32'h0);
        end

        // ---------------- reset during a write ----------------
        // last winner is 0, so requester 2 wins the search 1,2.
        req               = 4'b0100;
        we                = 4'b0100;
        addr[2*AW +: AW]  = 16'h0ABC;
        wdata[2*DW +: DW] = 8'h77;
        step();
        chk("rw_gnt",  32'(gnt),    32'h4);
        step();
        chk("rw_we",   32'(mem_we), 32'h1);
        reset = 1'b1;
        req   = 4'b0101;
        we    = 4'b0000;
        step();
        chk("rw_we_r",   32'(mem_we),   32'h0);
        chk("rw_oe_r",   32'(mem_oe),   32'h0);
        chk("rw_done_r", 32'(done),     32'h0);
        chk("rw_gnt_r",  32'(gnt),      32'h0);
        chk("rw_addr_r", 32'(mem_addr), 32'h0);
        chk("rw_rdata",  32'(rdata),    32'h0);
        reset = 1'b0;
        step();
        chk("rw_next",   32'(gnt),      32'h1);
        chk("rw_done_n", 32'(done),     32'h0);
        req = 4'b0000;
        step();
        step();
        step();
        chk("rw_done2",  32'(done),     32'h1);
        step();

`ifdef MEM_ARBITER_LOCK_EN
        // ---------------- bus lock ----------------
        reset = 1'b1;
        step();
        reset = 1'b0;
        req   = 4'b0101;
        for (int t = 0; t < 4; t++) begin
            lock = (t == 1) ? 4'b0100 : 4'b0000;
            step();
            chk("lock_gnt", 32'(gnt), (t == 0 || t == 3) ? 32'h1 : 32'h4);
            step();
            step();
            step();
            step();
        end
        req = 4'b0000;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
